// File: rtl/tdm_demux2to1.sv
// rtl/tdm_demux2to1.sv - receive side of a 2:1 TDM link, reassembles A/B sample pairs
module tdm_demux2to1 #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] dout_a,
    output logic [WIDTH-1:0] dout_b,
    output logic             pair_valid,
    output logic             sel_out,
    output logic             err,
    output logic [CNT_W-1:0] pair_cnt
);

    localparam int IDLE_W = 8;
    // Idle count value at which the next empty cycle expires the pair.
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        EXP_A     = 2'd1,
        EXP_B     = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_hold, a_hold_nxt;
    logic [WIDTH-1:0]  dout_a_nxt, dout_b_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
    logic [CNT_W-1:0]  pair_cnt_nxt;
    logic              pair_valid_nxt;
    logic              err_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= WAIT_SYNC;
            a_hold     <= '0;
            dout_a     <= '0;
            dout_b     <= '0;
            idle_cnt   <= '0;
            pair_cnt   <= '0;
            pair_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            a_hold     <= a_hold_nxt;
            dout_a     <= dout_a_nxt;
            dout_b     <= dout_b_nxt;
            idle_cnt   <= idle_cnt_nxt;
            pair_cnt   <= pair_cnt_nxt;
            pair_valid <= pair_valid_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        a_hold_nxt     = a_hold;
        dout_a_nxt     = dout_a;
        dout_b_nxt     = dout_b;
        idle_cnt_nxt   = idle_cnt;
        pair_cnt_nxt   = pair_cnt;
        pair_valid_nxt = 1'b0;
        err_nxt        = 1'b0;

        case (state)
            WAIT_SYNC: begin
                // Only an sof-flagged sample can start a pair while unsynchronised.
                if (din_valid && sof) begin
                    a_hold_nxt   = din;
                    idle_cnt_nxt = '0;
                    state_nxt    = EXP_B;
                end
            end
            EXP_A: begin
                if (din_valid) begin
                    a_hold_nxt   = din;
                    idle_cnt_nxt = '0;
                    state_nxt    = EXP_B;
                end
            end
            EXP_B: begin
                if (din_valid) begin
                    idle_cnt_nxt = '0;
                    if (sof) begin
                        // A second A before any B: restart the pair on the newer A.
                        err_nxt    = 1'b1;
                        a_hold_nxt = din;
                    end else begin
                        dout_a_nxt     = a_hold;
                        dout_b_nxt     = din;
                        pair_valid_nxt = 1'b1;
                        pair_cnt_nxt   = pair_cnt + CNT_W'(1);
                        state_nxt      = EXP_A;
                    end
                end else if (idle_cnt == IDLE_LAST) begin
                    err_nxt      = 1'b1;
                    a_hold_nxt   = '0;
                    idle_cnt_nxt = '0;
                    state_nxt    = WAIT_SYNC;
                end else begin
                    idle_cnt_nxt = idle_cnt + IDLE_W'(1);
                end
            end
            default: begin
                state_nxt = WAIT_SYNC;
            end
        endcase
    end

    assign sel_out = (state == EXP_B);

endmodule

// File: tb/tb_tdm_demux2to1.sv
// tb/tb_tdm_demux2to1.sv - randomized and directed bench for tdm_demux2to1
module tb_tdm_demux2to1;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             sof = 1'b0;
    logic [WIDTH-1:0] dout_a, dout_b;
    logic             pair_valid, sel_out, err;
    logic [CNT_W-1:0] pair_cnt;

    int checks = 0;
    int errors = 0;

    tdm_demux2to1 #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .sof(sof),
        .dout_a(dout_a), .dout_b(dout_b), .pair_valid(pair_valid), .sel_out(sel_out),
        .err(err), .pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;

    // Reference: "have an A waiting" plus "link has seen sync" flags.
    bit               m_synced, m_have_a;
    logic [WIDTH-1:0] m_a, m_dout_a, m_dout_b;
    logic [CNT_W-1:0] m_cnt;
    int               m_idle;
    bit               m_pv, m_err;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_synced = 0; m_have_a = 0; m_a = '0; m_idle = 0;
            m_dout_a = '0; m_dout_b = '0; m_cnt = '0; m_pv = 0; m_err = 0;
        end else begin
            m_pv = 0; m_err = 0;
            if (!m_have_a) begin
                if (din_valid && (sof || m_synced)) begin
                    m_have_a = 1; m_a = din; m_idle = 0;
                end
            end else if (din_valid && !sof) begin
                m_dout_a = m_a; m_dout_b = din; m_pv = 1;
                m_cnt = m_cnt + 1'b1;
                m_have_a = 0; m_synced = 1;
            end else if (din_valid) begin
                m_err = 1; m_a = din; m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle >= TIMEOUT) begin
                    m_err = 1; m_have_a = 0; m_synced = 0; m_a = '0; m_idle = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_dout_a", 32'(dout_a), 32'(m_dout_a));
        chk("cmp_dout_b", 32'(dout_b), 32'(m_dout_b));
        chk("cmp_pair_valid", 32'(pair_valid), 32'(m_pv));
        chk("cmp_err", 32'(err), 32'(m_err));
        chk("cmp_sel_out", 32'(sel_out), 32'(m_have_a));
        chk("cmp_pair_cnt", 32'(pair_cnt), 32'(m_cnt));
    end

    // Drive one cycle of input; return just after the edge that consumed it.
    task automatic step(input bit v, input bit s, input logic [WIDTH-1:0] d);
        @(negedge clk);
        din_valid = v; sof = s; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #2;
        resetn = 0; din_valid = 0; sof = 0;
        repeat (cycles) @(posedge clk);
        #2;
        resetn = 1;
    endtask

    task automatic send_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        step(1, 1, a);
        step(1, 0, b);
    endtask

    initial begin
        bit want_a;
        int burst;
        // Reset then idle
        do_reset(3);
        #1;
        chk("rst_dout_a", 32'(dout_a), 0);
        chk("rst_dout_b", 32'(dout_b), 0);
        chk("rst_pair_valid", 32'(pair_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_sel_out", 32'(sel_out), 0);
        chk("rst_pair_cnt", 32'(pair_cnt), 0);
        step(1, 0, 8'h55);
        chk("drop_pv", 32'(pair_valid), 0);
        chk("drop_err", 32'(err), 0);
        chk("drop_sel", 32'(sel_out), 0);

        // Basic pair
        step(1, 1, 8'h12);
        chk("basic_sel_b", 32'(sel_out), 1);
        chk("basic_pv_early", 32'(pair_valid), 0);
        step(1, 0, 8'h34);
        chk("basic_dout_a", 32'(dout_a), 32'h12);
        chk("basic_dout_b", 32'(dout_b), 32'h34);
        chk("basic_pv", 32'(pair_valid), 1);
        chk("basic_cnt", 32'(pair_cnt), 1);
        chk("basic_sel_a", 32'(sel_out), 0);
        step(0, 0, 8'h00);
        chk("basic_pv_drop", 32'(pair_valid), 0);
        chk("basic_hold_a", 32'(dout_a), 32'h12);

        // Streaming
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 8'(8'h10 + i));
            chk("stream_pv_a", 32'(pair_valid), 0);
            step(1, 0, 8'(8'h20 + i));
            chk("stream_pv_b", 32'(pair_valid), 1);
        end
        chk("stream_dout_a", 32'(dout_a), 32'h13);
        chk("stream_dout_b", 32'(dout_b), 32'h23);
        chk("stream_cnt", 32'(pair_cnt), 4);

        // Misalignment
        step(1, 1, 8'hAA);
        chk("mis_err0", 32'(err), 0);
        step(1, 1, 8'hBB);
        chk("mis_err1", 32'(err), 1);
        chk("mis_sel", 32'(sel_out), 1);
        step(1, 0, 8'hCC);
        chk("mis_err2", 32'(err), 0);
        chk("mis_pv", 32'(pair_valid), 1);
        chk("mis_dout_a", 32'(dout_a), 32'hBB);
        chk("mis_dout_b", 32'(dout_b), 32'hCC);
        chk("mis_cnt", 32'(pair_cnt), 5);

        // Timeout
        step(1, 1, 8'h01);
        for (int i = 1; i < TIMEOUT; i++) begin
            step(0, 0, 8'h00);
            chk("to_no_err", 32'(err), 0);
            chk("to_sel_hold", 32'(sel_out), 1);
        end
        step(0, 0, 8'h00);
        chk("to_err", 32'(err), 1);
        chk("to_sel", 32'(sel_out), 0);
        step(1, 0, 8'h02);
        chk("to_drop_pv", 32'(pair_valid), 0);
        chk("to_drop_err", 32'(err), 0);
        chk("to_drop_sel", 32'(sel_out), 0);
        send_pair(8'h03, 8'h04);
        chk("to_pair_pv", 32'(pair_valid), 1);
        chk("to_pair_a", 32'(dout_a), 32'h03);
        chk("to_pair_b", 32'(dout_b), 32'h04);

        // Reset mid-pair plus wrap
        do_reset(2);
        for (int i = 0; i < 15; i++) send_pair(8'(i), 8'(8'h80 + i));
        chk("wrap_cnt15", 32'(pair_cnt), 15);
        step(1, 1, 8'h77);
        @(negedge clk);
        #1;
        resetn = 0; din_valid = 0;
        #1;
        chk("midrst_cnt", 32'(pair_cnt), 0);
        chk("midrst_pv", 32'(pair_valid), 0);
        chk("midrst_err", 32'(err), 0);
        chk("midrst_sel", 32'(sel_out), 0);
        @(posedge clk);
        #2;
        resetn = 1;
        for (int i = 0; i < 17; i++) send_pair(8'(8'h40 + i), 8'(8'hC0 + i));
        chk("wrap_cnt1", 32'(pair_cnt), 1);
        chk("wrap_a", 32'(dout_a), 32'h50);
        chk("wrap_b", 32'(dout_b), 32'hD0);

        // Randomized traffic against the reference
        want_a = 1;
        burst = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 999) < 3) begin
                do_reset($urandom_range(1, 2));
                want_a = 1;
            end else if (burst > 0) begin
                burst--;
                step(0, 0, 8'($urandom));
            end else begin
                int r = $urandom_range(0, 99);
                if (r < 3) begin
                    burst = $urandom_range(TIMEOUT - 3, TIMEOUT + 3);
                    step(0, 0, 8'($urandom));
                end else if (r < 30) begin
                    step(0, $urandom_range(0, 1) == 1, 8'($urandom));
                end else begin
                    bit s = ($urandom_range(0, 99) < 12) ? ~want_a : want_a;
                    step(1, s, 8'($urandom));
                    want_a = ~s;
                end
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
